i2s_capture_sequencer: RTL
==========================

// Module: i2s_capture_sequencer
// PURPOSE
//  Sequences capture windows on the i2s_controller output: armed by a start pulse,
//  discards SKIP_FRAMES settling frames, then captures num_frames stereo frames.
//  Frames pass through a small FIFO to a valid/ready stream consumer.
//  Sits between i2s_controller (data_valid/data_out_0/data_out_1) and a DMA/UART sink.
// PARAMETERS
//  SAMPLE_WIDTH     32  width of each channel word
//  COUNT_WIDTH      16  width of num_frames / frame counters
//  FIFO_DEPTH_LOG2  3   FIFO holds 2**FIFO_DEPTH_LOG2 frames (default 8)
//  SKIP_FRAMES      2   frames discarded after arming; 0 = capture immediately
// PORTS
//  clock            in   1               system clock, all logic on posedge
//  reset            in   1               asynchronous, active-high
//  start            in   1               one-cycle arm pulse; ignored unless idle
//  abort            in   1               cancel capture, flush FIFO
//  num_frames       in   COUNT_WIDTH     frames to capture, sampled on start; 0 = until abort
//  i2s_data_valid   in   1               one-cycle strobe per frame from i2s_controller
//  i2s_data_0       in   SAMPLE_WIDTH    channel 0 (lrck phase 0) sample
//  i2s_data_1       in   SAMPLE_WIDTH    channel 1 sample
//  m_valid          out  1               stream head valid
//  m_ready          in   1               consumer accepts head when m_valid&m_ready
//  m_data           out  2*SAMPLE_WIDTH  {ch1, ch0} of FIFO head
//  busy             out  1               high in every state except IDLE
//  done             out  1               one-cycle pulse at normal completion
//  overflow         out  1               sticky: a frame was dropped on a full FIFO
//  frames_captured  out  COUNT_WIDTH     frames pushed into the FIFO this run
// BEHAVIOUR
//  - Reset: state=IDLE, FIFO empty, all outputs 0 (m_valid, m_data, busy, done,
//    overflow, frames_captured).
//  - States: IDLE -> SKIP -> CAPTURE -> DRAIN -> IDLE.
//  - IDLE: start (without abort) latches num_frames; clears overflow,
//    frames_captured and the frame counter. Next state SKIP, or CAPTURE if SKIP_FRAMES==0.
//  - A data_valid strobe in the same cycle as start is not captured.
//  - SKIP: counts i2s_data_valid strobes, discards data. On the SKIP_FRAMES-th strobe -> CAPTURE.
//  - CAPTURE: each strobe counts one frame. If the FIFO is not full (or a pop
//    occurs that cycle), {i2s_data_1,i2s_data_0} is pushed and frames_captured
//    increments. Otherwise the frame is dropped and overflow is set.
//  - Dropped frames still count toward num_frames, so the window length is fixed in time.
//  - CAPTURE exits to DRAIN in the cycle after the num_frames-th strobe. With num_frames==0 it never exits.
//  - DRAIN: no pushes. When the FIFO is empty, done pulses for 1 cycle and the state returns to IDLE.
//  - abort in any non-IDLE state: next cycle state=IDLE, FIFO flushed, m_valid=0,
//    no done pulse. overflow and frames_captured hold their values.
//  - abort has priority over start and over a push in the same cycle.
//  - start while busy is ignored. done is never asserted together with busy=0 in the same cycle as a new start.
//  - FIFO: first-word-fall-through; m_valid/m_data registered.
//  - A push into an empty FIFO gives m_valid=1 on the next clock (1-cycle latency).
//  - Simultaneous push and pop: count unchanged; a pop while full frees a slot for the same-cycle push.
//  - Pointers wrap modulo 2**FIFO_DEPTH_LOG2; a separate occupancy count distinguishes full from empty.
//  - frames_captured saturates at all-ones and does not wrap.
// CONFIGURATION
//  I2S_CAPTURE_SEQ_CHECKSUM_EN defined: adds output port checksum [31:0].
//  - Running sum mod 2**32 of ch0+ch1 (each zero-extended or truncated to 32b) over every pushed frame.
//  - Cleared on accepted start; reset value 0; held after done or abort.
//  Undefined: port and logic absent, all other behaviour identical.
// TESTING
//  1. SKIP_FRAMES=2, num_frames=4, m_ready=1, frames 1..6 -> frames 3,4,5,6 emitted
//     in order; done 1 pulse; frames_captured=4; overflow=0.
//  2. Depth 8, m_ready=0, num_frames=10 -> 8 pushed, overflow=1, frames_captured=8.
//     Then m_ready=1 -> 8 words drain, done pulses after the last pop.
//  3. num_frames=0, 20 strobes -> 20 words emitted, busy stays 1.
//     abort -> busy=0 next cycle, m_valid=0, done never pulses.
//  4. start and abort in the same IDLE cycle -> stays IDLE, busy=0.
//     start during CAPTURE -> ignored, counts unchanged.
//  5. Async reset asserted mid-CAPTURE between clock edges -> outputs 0 immediately, FIFO empty.
//  6. CHECKSUM_EN, frames {1,2},{3,4} -> checksum=10.
//     Push while full with a same-cycle pop -> accepted, overflow=0.

Source files
------------

// File: rtl/i2s_capture_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_capture_sequencer: arms on start, skips settling frames, captures a    |
// | fixed-length window of stereo frames into a FWFT FIFO feeding a stream.    |
// | Optional: I2S_CAPTURE_SEQ_CHECKSUM_EN adds a running 32-bit checksum port. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2s_capture_sequencer #(
   parameter int SAMPLE_WIDTH    = 32,
   parameter int COUNT_WIDTH     = 16,
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int SKIP_FRAMES     = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [COUNT_WIDTH-1:0]    num_frames,
   input  logic                      i2s_data_valid,
   input  logic [SAMPLE_WIDTH-1:0]   i2s_data_0,
   input  logic [SAMPLE_WIDTH-1:0]   i2s_data_1,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [2*SAMPLE_WIDTH-1:0] m_data,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic [COUNT_WIDTH-1:0]    frames_captured
`ifdef I2S_CAPTURE_SEQ_CHECKSUM_EN
   ,
   output logic [31:0]               checksum
`endif
);

   localparam int c_DEPTH  = 2 ** FIFO_DEPTH_LOG2;
   localparam int c_SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
   localparam int c_CNT_W  = FIFO_DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SKIP    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   state_t                      r_state;
   state_t                      w_state_next;

   logic [COUNT_WIDTH-1:0]      r_target;
   logic [COUNT_WIDTH-1:0]      r_frame_cnt;
   logic [c_SKIP_W-1:0]         r_skip_cnt;
   logic                        r_overflow;
   logic [COUNT_WIDTH-1:0]      r_frames_captured;

   logic [2*SAMPLE_WIDTH-1:0]   r_mem [c_DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0]  r_wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]          r_count;
   logic                        r_m_valid;
   logic [2*SAMPLE_WIDTH-1:0]   r_m_data;

   logic                        w_abort;
   logic                        w_start_ok;
   logic                        w_skip_last;
   logic                        w_frame_last;
   logic                        w_full;
   logic                        w_pop;
   logic                        w_push_req;
   logic                        w_push;
   logic                        w_drop;
   logic [2*SAMPLE_WIDTH-1:0]   w_frame;
   logic [c_CNT_W-1:0]          w_count_after_pop;
   logic [c_CNT_W-1:0]          w_count_next;
   logic [FIFO_DEPTH_LOG2-1:0]  w_rd_next;
   logic [2*SAMPLE_WIDTH-1:0]   w_head_next;

   assign w_abort      = abort & (r_state != ST_IDLE);
   assign w_start_ok   = (r_state == ST_IDLE) & start & ~abort;
   assign w_skip_last  = (({1'b0, r_skip_cnt} + (c_SKIP_W + 1)'(1)) == (c_SKIP_W + 1)'(SKIP_FRAMES));
   assign w_frame_last = (r_target != '0) && ((r_frame_cnt + COUNT_WIDTH'(1)) == r_target);

   assign w_full     = (r_count == c_CNT_W'(c_DEPTH));
   assign w_pop      = r_m_valid & m_ready;
   assign w_push_req = (r_state == ST_CAPTURE) & i2s_data_valid & ~abort;
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & ~w_push;
   assign w_frame    = {i2s_data_1, i2s_data_0};

   assign w_count_after_pop = r_count - c_CNT_W'(w_pop);
   assign w_count_next      = w_count_after_pop + c_CNT_W'(w_push);
   assign w_rd_next         = r_rd_ptr + FIFO_DEPTH_LOG2'(w_pop);
   // The head register is reloaded from the new read slot, or straight from the
   // incoming frame when that frame lands in an otherwise empty FIFO.
   assign w_head_next       = (w_count_after_pop == '0) ? w_frame : r_mem[w_rd_next];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) begin
               w_state_next = (SKIP_FRAMES == 0) ? ST_CAPTURE : ST_SKIP;
            end
         end
         ST_SKIP: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (i2s_data_valid && w_skip_last) begin
               w_state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (i2s_data_valid && w_frame_last) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (r_count == '0) begin
               done         = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_target          <= '0;
         r_frame_cnt       <= '0;
         r_skip_cnt        <= '0;
         r_overflow        <= 1'b0;
         r_frames_captured <= '0;
      end else if (w_start_ok) begin
         r_target          <= num_frames;
         r_frame_cnt       <= '0;
         r_skip_cnt        <= '0;
         r_overflow        <= 1'b0;
         r_frames_captured <= '0;
      end else begin
         if ((r_state == ST_SKIP) && i2s_data_valid && !w_abort) begin
            r_skip_cnt <= r_skip_cnt + c_SKIP_W'(1);
         end
         // Dropped frames still advance the window so its length is fixed in time.
         if ((r_state == ST_CAPTURE) && i2s_data_valid && !w_abort) begin
            r_frame_cnt <= r_frame_cnt + COUNT_WIDTH'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_push && (r_frames_captured != '1)) begin
            r_frames_captured <= r_frames_captured + COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_frame;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
      end else if (w_abort) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_m_valid <= 1'b0;
      end else begin
         r_wr_ptr  <= r_wr_ptr + FIFO_DEPTH_LOG2'(w_push);
         r_rd_ptr  <= w_rd_next;
         r_count   <= w_count_next;
         r_m_valid <= (w_count_next != '0);
         if (w_count_next != '0) begin
            r_m_data <= w_head_next;
         end
      end
   end

   assign m_valid         = r_m_valid;
   assign m_data          = r_m_data;
   assign busy            = (r_state != ST_IDLE);
   assign overflow        = r_overflow;
   assign frames_captured = r_frames_captured;

`ifdef I2S_CAPTURE_SEQ_CHECKSUM_EN
   logic [31:0] r_checksum;
   logic [31:0] w_ch0_32;
   logic [31:0] w_ch1_32;

   generate
      if (SAMPLE_WIDTH >= 32) begin : g_sum_trunc
         assign w_ch0_32 = i2s_data_0[31:0];
         assign w_ch1_32 = i2s_data_1[31:0];
      end else begin : g_sum_ext
         assign w_ch0_32 = {{(32 - SAMPLE_WIDTH){1'b0}}, i2s_data_0};
         assign w_ch1_32 = {{(32 - SAMPLE_WIDTH){1'b0}}, i2s_data_1};
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_checksum <= '0;
      end else if (w_start_ok) begin
         r_checksum <= '0;
      end else if (w_push) begin
         r_checksum <= r_checksum + w_ch0_32 + w_ch1_32;
      end
   end

   assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire
